// File: rtl/adc_spi_capture.sv
// SPI capture for the dual-channel 14-bit ADC: AD_CONV pulse, 34 SCK periods, two samples out.
// Optional build macro ADC_OFFSET_BINARY_EN delivers Va/Vb in offset binary (MSB inverted).
module adc_spi_capture #(
   parameter int SCK_HALF_DIV = 2
) (
   input  logic        CLK_50M,
   input  logic        reset,
   input  logic        startEnable,
   input  logic        SPI_MISO,
   output logic        SPI_SCK,
   output logic        AD_CONV,
   output logic        busy,
   output logic        dataValid,
   output logic [13:0] Va,
   output logic [13:0] Vb
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONV  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [7:0] L_HALF_LAST = 8'(SCK_HALF_DIV - 1);
   localparam logic [5:0] L_BIT_LAST  = 6'd33;

   state_t      r_state;
   logic [7:0]  r_half_cnt;
   logic [5:0]  r_bit_cnt;
   logic        r_phase;
   logic        r_sck;
   logic        r_ad_conv;
   logic        r_busy;
   logic        r_data_valid;
   logic [13:0] r_sh0;
   logic [13:0] r_sh1;
   logic [13:0] r_va;
   logic [13:0] r_vb;

   logic w_half_end;
   logic w_in_ch0;
   logic w_in_ch1;

   function automatic logic [13:0] fmt_sample(input logic [13:0] raw);
`ifdef ADC_OFFSET_BINARY_EN
      return {~raw[13], raw[12:0]};
`else
      return raw;
`endif
   endfunction

   assign w_half_end = (r_half_cnt == L_HALF_LAST);
   assign w_in_ch0   = (r_bit_cnt >= 6'd2)  && (r_bit_cnt <= 6'd15);
   assign w_in_ch1   = (r_bit_cnt >= 6'd18) && (r_bit_cnt <= 6'd31);

   // r_phase selects the low (0) or high (1) half of the current SCK period / AD_CONV window
   always_ff @(posedge CLK_50M) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_half_cnt   <= 8'd0;
         r_bit_cnt    <= 6'd0;
         r_phase      <= 1'b0;
         r_sck        <= 1'b0;
         r_ad_conv    <= 1'b0;
         r_busy       <= 1'b0;
         r_data_valid <= 1'b0;
         r_sh0        <= 14'd0;
         r_sh1        <= 14'd0;
         r_va         <= 14'd0;
         r_vb         <= 14'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_data_valid <= 1'b0;
               r_sck        <= 1'b0;
               if (startEnable) begin
                  r_state    <= ST_CONV;
                  r_ad_conv  <= 1'b1;
                  r_busy     <= 1'b1;
                  r_half_cnt <= 8'd0;
                  r_bit_cnt  <= 6'd0;
                  r_phase    <= 1'b0;
               end
            end
            ST_CONV: begin
               if (w_half_end) begin
                  r_half_cnt <= 8'd0;
                  if (r_phase) begin
                     r_state   <= ST_SHIFT;
                     r_ad_conv <= 1'b0;
                     r_bit_cnt <= 6'd0;
                     r_phase   <= 1'b0;
                  end else begin
                     r_phase <= 1'b1;
                  end
               end else begin
                  r_half_cnt <= r_half_cnt + 8'd1;
               end
            end
            ST_SHIFT: begin
               if (w_half_end) begin
                  r_half_cnt <= 8'd0;
                  if (!r_phase) begin
                     // This edge raises SCK, so MISO is taken now
                     r_phase <= 1'b1;
                     r_sck   <= 1'b1;
                     if (w_in_ch0) begin
                        r_sh0 <= {r_sh0[12:0], SPI_MISO};
                     end
                     if (w_in_ch1) begin
                        r_sh1 <= {r_sh1[12:0], SPI_MISO};
                     end
                  end else begin
                     r_phase <= 1'b0;
                     r_sck   <= 1'b0;
                     if (r_bit_cnt == L_BIT_LAST) begin
                        r_state      <= ST_DONE;
                        r_va         <= fmt_sample(r_sh0);
                        r_vb         <= fmt_sample(r_sh1);
                        r_data_valid <= 1'b1;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                     end
                  end
               end else begin
                  r_half_cnt <= r_half_cnt + 8'd1;
               end
            end
            ST_DONE: begin
               r_state      <= ST_IDLE;
               r_data_valid <= 1'b0;
               r_busy       <= 1'b0;
            end
            default: begin
               r_state      <= ST_IDLE;
               r_sck        <= 1'b0;
               r_ad_conv    <= 1'b0;
               r_busy       <= 1'b0;
               r_data_valid <= 1'b0;
            end
         endcase
      end
   end

   assign SPI_SCK   = r_sck;
   assign AD_CONV   = r_ad_conv;
   assign busy      = r_busy;
   assign dataValid = r_data_valid;
   assign Va        = r_va;
   assign Vb        = r_vb;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench for adc_spi_capture with a bit-level ADC model and an expected-sample queue.
`timescale 1ns/1ps
module tb_adc_spi_capture;
   localparam int D = 2;

   logic        CLK_50M = 1'b0;
   logic        reset = 1'b1;
   logic        startEnable = 1'b0;
   logic        SPI_MISO = 1'b0;
   logic        SPI_SCK;
   logic        AD_CONV;
   logic        busy;
   logic        dataValid;
   logic [13:0] Va;
   logic [13:0] Vb;

   adc_spi_capture #(.SCK_HALF_DIV(D)) dut (
      .CLK_50M(CLK_50M), .reset(reset), .startEnable(startEnable), .SPI_MISO(SPI_MISO),
      .SPI_SCK(SPI_SCK), .AD_CONV(AD_CONV), .busy(busy), .dataValid(dataValid),
      .Va(Va), .Vb(Vb)
   );

   always #10 CLK_50M = ~CLK_50M;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          t0 = 0;
   int          bit_idx = 0;
   int          sck_rises = 0;
   int          conv_rises = 0;
   int          dv_count = 0;
   int          dv_rel = -1;
   int          unexpected_dv = 0;
   logic        prev_sck = 1'b0;
   logic        prev_conv = 1'b0;
   logic [33:0] frame = 34'd0;
   logic [27:0] exp_q[$];

   function automatic logic [13:0] fmt(input logic [13:0] raw);
`ifdef ADC_OFFSET_BINARY_EN
      return {~raw[13], raw[12:0]};
`else
      return raw;
`endif
   endfunction

   function automatic logic [33:0] mk_frame(input logic [13:0] c0, input logic [13:0] c1,
                                            input logic [1:0] gap);
      return {gap, c0, gap, c1, gap};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: ADC model reacts to SCK falls, then outputs are observed 1 ns after the edge
   task automatic tick();
      logic [27:0] e;
      @(posedge CLK_50M);
      cyc++;
      #1;
      if (AD_CONV === 1'b1 && prev_conv !== 1'b1) begin
         conv_rises++;
         bit_idx  = 0;
         SPI_MISO = frame[33];
      end
      if (prev_sck === 1'b1 && SPI_SCK === 1'b0) begin
         bit_idx++;
         if (bit_idx < 34) SPI_MISO = frame[33 - bit_idx];
      end
      if (SPI_SCK === 1'b1 && prev_sck !== 1'b1) sck_rises++;
      prev_sck  = SPI_SCK;
      prev_conv = AD_CONV;
      if (dataValid === 1'b1) begin
         dv_count++;
         dv_rel = cyc - t0 + 1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_va", {18'd0, Va}, {18'd0, e[27:14]});
            check("sb_vb", {18'd0, Vb}, {18'd0, e[13:0]});
         end else begin
            unexpected_dv++;
         end
      end
   endtask

   task automatic start_conv(input logic [13:0] c0, input logic [13:0] c1, input logic [1:0] gap);
      frame = mk_frame(c0, c1, gap);
      exp_q.push_back({fmt(c0), fmt(c1)});
      startEnable = 1'b1;
      tick();
      t0 = cyc;
      startEnable = 1'b0;
   endtask

   task automatic run_to_rel(input int last_rel);
      while (cyc - t0 + 1 < last_rel) tick();
   endtask

   initial begin
      int base_rises;
      int dv0;
      int cr0;
      int adconv_bad;
      int rel;
      int sv;
      int t_prev;

      // Reset
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      check("rst_sck", {31'd0, SPI_SCK}, 32'd0);
      check("rst_adconv", {31'd0, AD_CONV}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_dv", {31'd0, dataValid}, 32'd0);
      check("rst_va", {18'd0, Va}, 32'd0);
      check("rst_vb", {18'd0, Vb}, 32'd0);
      base_rises = sck_rises;
      repeat (200) tick();
      check("idle_sck_quiet", sck_rises - base_rises, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Single conversion
      base_rises = sck_rises;
      dv0 = dv_count;
      adconv_bad = 0;
      start_conv(14'h1FFF, 14'h2000, 2'b00);
      while (cyc - t0 + 1 <= 150) begin
         rel = cyc - t0 + 1;
         if (AD_CONV !== ((rel >= 1) && (rel <= 2 * D))) adconv_bad++;
         if (rel == 2 && busy !== 1'b1) adconv_bad++;
         tick();
      end
      check("adconv_window", adconv_bad, 32'd0);
      check("sck_rise_count", sck_rises - base_rises, 32'd34);
      check("single_dv_count", dv_count - dv0, 32'd1);
      check("single_dv_cycle", dv_rel, 70 * D + 1);
      sv = $signed(Va);
`ifdef ADC_OFFSET_BINARY_EN
      check("va_ob", {18'd0, Va}, 32'h0000_3FFF);
      check("vb_ob", {18'd0, Vb}, 32'h0000_0000);
`else
      check("va_signed", sv, 32'd8191);
      sv = $signed(Vb);
      check("vb_signed", sv, 32'hFFFF_E000);
`endif
      check("post_done_busy", {31'd0, busy}, 32'd0);

      // Gap bits must be discarded
      dv0 = dv_count;
      start_conv(14'h0000, 14'h0000, 2'b11);
      run_to_rel(150);
      check("gap_dv_count", dv_count - dv0, 32'd1);
      check("gap_va", {18'd0, Va}, {18'd0, fmt(14'h0000)});
      check("gap_vb", {18'd0, Vb}, {18'd0, fmt(14'h0000)});

      // Start while busy, then back-to-back start
      dv0 = dv_count;
      cr0 = conv_rises;
      start_conv(14'h0ABC, 14'h3543, 2'b00);
      while (cyc - t0 < 141) begin
         startEnable = ((cyc - t0 == 49) || (cyc - t0 == 139)) ? 1'b1 : 1'b0;
         tick();
      end
      startEnable = 1'b0;
      check("busy_conv_count", conv_rises - cr0, 32'd1);
      check("busy_dv_count", dv_count - dv0, 32'd1);
      check("busy_dv_cycle", dv_rel, 70 * D + 1);
      t_prev = t0;
      start_conv(14'h0ABC, 14'h3543, 2'b00);
      check("b2b_accept_edge", t0 - t_prev, 70 * D + 2);
      check("b2b_adconv", {31'd0, AD_CONV}, 32'd1);
      check("b2b_busy", {31'd0, busy}, 32'd1);
      run_to_rel(150);
      check("b2b_dv_count", dv_count - dv0, 32'd2);

      // Reset mid-shift drops the frame
      start_conv(14'h1234, 14'h2345, 2'b00);
      while (cyc - t0 < 59) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      void'(exp_q.pop_back());
      check("mid_rst_sck", {31'd0, SPI_SCK}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_adconv", {31'd0, AD_CONV}, 32'd0);
      check("mid_rst_va", {18'd0, Va}, 32'd0);
      check("mid_rst_vb", {18'd0, Vb}, 32'd0);
      dv0 = dv_count;
      repeat (200) tick();
      check("mid_rst_no_dv", dv_count - dv0, 32'd0);

      // Reset wins over start
      reset = 1'b1;
      startEnable = 1'b1;
      tick();
      reset = 1'b0;
      startEnable = 1'b0;
      check("rst_start_busy", {31'd0, busy}, 32'd0);
      check("rst_start_adconv", {31'd0, AD_CONV}, 32'd0);
      tick();
      check("rst_start_busy2", {31'd0, busy}, 32'd0);

      // Offset-binary format sample
      start_conv(14'h0000, 14'h3FFF, 2'b00);
      run_to_rel(150);
`ifdef ADC_OFFSET_BINARY_EN
      check("ob_va", {18'd0, Va}, 32'h0000_2000);
      check("ob_vb", {18'd0, Vb}, 32'h0000_1FFF);
`else
      check("raw_va", {18'd0, Va}, 32'h0000_0000);
      check("raw_vb", {18'd0, Vb}, 32'h0000_3FFF);
`endif

      check("sb_empty", exp_q.size(), 32'd0);
      check("unexpected_dv", unexpected_dv, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
